qm_fetch: RTL and testbench

QM_FETCH -- requirements
Module: qm_fetch

---
 rtl/qm_pkg.sv | 26 ++
 rtl/qm_sat_counter.sv | 33 +++
 rtl/qm_fetch.sv | 170 +++++++++++++++++
 tb/tb_qm_fetch.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/qm_pkg.sv
// ============================================================================
// Module   : qm_pkg
// Brief    : Shared constants and FSM encoding for the qm_fetch front end.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package qm_pkg;

    localparam int          c_instr_width  = 32;
    localparam logic [31:0] c_reset_vector = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_MISS = 2'd2
    } qm_state_e;

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] qm_align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/qm_sat_counter.sv
// ============================================================================
// Module   : qm_sat_counter
// Brief    : Up counter that sticks at all-ones instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qm_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/qm_fetch.sv
// ============================================================================
// Module   : qm_fetch
// Brief    : Instruction fetch stage: PC sequencing, I-cache miss wait,
//            redirect handling and a one-entry decode-side output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qm_fetch
    import qm_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = c_reset_vector
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [31:0]              icache_address,
    output logic                     icache_enable,
    input  logic                     icache_hit,
    input  logic                     icache_stall,
    input  logic [c_instr_width-1:0] icache_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_target,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [c_instr_width-1:0] out_instr,
    output logic [31:0]              out_pc,
    output logic [15:0]              perf_stall_cycles,
    output logic [31:0]              perf_fetched
);

    qm_state_e r_state;
    qm_state_e w_state_nxt;
    logic      w_enable;

    logic [31:0]              r_pc;
    logic                     r_out_valid;
    logic [c_instr_width-1:0] r_out_instr;
    logic [31:0]              r_out_pc;
    logic                     r_pend_valid;
    logic [31:0]              r_pend_target;
    logic [31:0]              r_fetched;

    logic        w_take;
    logic        w_miss_exit;
    logic        w_handshake;
    logic [31:0] w_redirect_pc;
    logic        w_unused_target_bits;

    assign w_redirect_pc        = qm_align_word(redirect_target);
    assign w_unused_target_bits = ^redirect_target[1:0];
    assign w_handshake          = r_out_valid & out_ready;

    assign w_take = (r_state == ST_RUN) & icache_hit & ~icache_stall
                  & (~r_out_valid | out_ready) & ~redirect_valid;

    assign w_miss_exit = (r_state == ST_MISS) & icache_hit & ~icache_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A redirect in RUN wins over a stall: the new address starts a fresh lookup.
    always_comb begin
        w_state_nxt = r_state;
        w_enable    = 1'b0;
        unique case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_enable = 1'b1;
                if (!redirect_valid && icache_stall) begin
                    w_state_nxt = ST_MISS;
                end
            end
            ST_MISS: begin
                w_enable = 1'b1;
                if (icache_hit && !icache_stall) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    // The miss address must stay put until the fill completes; redirects wait.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_VECTOR;
        end else begin
            unique case (r_state)
                ST_BOOT: begin
                    if (redirect_valid) r_pc <= w_redirect_pc;
                end
                ST_RUN: begin
                    if (redirect_valid)  r_pc <= w_redirect_pc;
                    else if (w_take)     r_pc <= r_pc + 32'd4;
                end
                ST_MISS: begin
                    if (w_miss_exit) begin
                        if (redirect_valid)    r_pc <= w_redirect_pc;
                        else if (r_pend_valid) r_pc <= r_pend_target;
                    end
                end
                default: r_pc <= RESET_VECTOR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (r_state == ST_MISS) begin
            if (w_miss_exit) begin
                r_pend_valid <= 1'b0;
            end else if (redirect_valid) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_redirect_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_pc    <= '0;
        end else if (w_take) begin
            r_out_valid <= 1'b1;
            r_out_instr <= icache_data;
            r_out_pc    <= r_pc;
        end else if (redirect_valid || w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetched <= '0;
        end else if (w_handshake) begin
            r_fetched <= r_fetched + 32'd1;
        end
    end

    qm_sat_counter #(
        .WIDTH (16)
    ) u_stall_counter (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (r_state == ST_MISS),
        .o_count (perf_stall_cycles)
    );

    assign icache_address = r_pc;
    assign icache_enable  = w_enable;
    assign out_valid      = r_out_valid;
    assign out_instr      = r_out_instr;
    assign out_pc         = r_out_pc;
    assign perf_fetched   = r_fetched;

endmodule

`default_nettype wire

// File: tb/tb_qm_fetch.sv
// ============================================================================
// Module   : tb_qm_fetch
// Brief    : Directed and randomized checks of qm_fetch against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qm_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] icache_address;
    logic        icache_enable;
    logic        icache_hit;
    logic        icache_stall;
    logic [31:0] icache_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [15:0] perf_stall_cycles;
    logic [31:0] perf_fetched;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    qm_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .icache_address    (icache_address),
        .icache_enable     (icache_enable),
        .icache_hit        (icache_hit),
        .icache_stall      (icache_stall),
        .icache_data       (icache_data),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_instr         (out_instr),
        .out_pc            (out_pc),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_fetched      (perf_fetched)
    );

    // Cache contents are a fixed scramble of the address, so any word is predictable.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign icache_data = instr_of(icache_address);

    // Behavioural model: mode 0 = boot, 1 = running, 2 = waiting on a fill.
    int          m_mode;
    logic [31:0] m_pc, m_opc, m_oi, m_pt, m_fetched;
    logic        m_ov, m_pv;
    int          m_stalls;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_tick(input logic r, h, s, v, input logic [31:0] t, input logic y);
        logic [31:0] tgt;
        tgt = t & ~32'd3;
        if (r) begin
            m_mode = 0; m_pc = 32'h8000_0000; m_ov = 0; m_oi = 0; m_opc = 0;
            m_pv = 0; m_pt = 0; m_stalls = 0; m_fetched = 0;
            return;
        end
        if (m_ov && y) m_fetched = m_fetched + 1;
        if (m_mode == 0) begin
            m_mode = 1;
            if (v) m_pc = tgt;
        end else if (m_mode == 1) begin
            if (v) begin
                m_pc = tgt; m_ov = 0;
            end else if (s) begin
                m_mode = 2;
                if (m_ov && y) m_ov = 0;
            end else if (h && (!m_ov || y)) begin
                m_oi = instr_of(m_pc); m_opc = m_pc; m_ov = 1; m_pc = m_pc + 4;
            end else if (m_ov && y) begin
                m_ov = 0;
            end
        end else begin
            if (m_stalls < 65535) m_stalls++;
            if (v || (m_ov && y)) m_ov = 0;
            if (h && !s) begin
                m_mode = 1;
                if (v) m_pc = tgt;
                else if (m_pv) m_pc = m_pt;
                m_pv = 0;
            end else if (v) begin
                m_pv = 1; m_pt = tgt;
            end
        end
    endtask

    task automatic step(input logic r, h, s, v, input logic [31:0] t, input logic y);
        reset = r; icache_hit = h; icache_stall = s;
        redirect_valid = v; redirect_target = t; out_ready = y;
        model_tick(r, h, s, v, t, y);
        @(posedge clk);
        @(negedge clk);
        chk("icache_address", icache_address, m_pc);
        chk("icache_enable", {31'd0, icache_enable}, {31'd0, m_mode != 0});
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
        if (m_ov) begin
            chk("out_pc", out_pc, m_opc);
            chk("out_instr", out_instr, m_oi);
        end
        chk("perf_stall_cycles", {16'd0, perf_stall_cycles}, m_stalls);
        chk("perf_fetched", perf_fetched, m_fetched);
    endtask

    initial begin
        int burst;
        logic [31:0] tgt;
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1);
        chk("reset_out_pc", out_pc, 32'h0);
        chk("reset_out_instr", out_instr, 32'h0);

        // Straight-line hits after reset.
        step(0, 1, 0, 0, 0, 1);
        chk("boot_no_valid", {31'd0, out_valid}, 32'd0);
        step(0, 1, 0, 0, 0, 1);
        chk("first_pc", out_pc, 32'h8000_0000);
        step(0, 1, 0, 0, 0, 1);
        chk("second_pc", out_pc, 32'h8000_0004);
        step(0, 1, 0, 0, 0, 1);
        chk("third_pc", out_pc, 32'h8000_0008);
        step(0, 1, 0, 0, 0, 1);

        // Six-cycle fill at 80000010.
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0, 0, 1);
            chk("miss_addr_hold", icache_address, 32'h8000_0010);
        end
        step(0, 1, 0, 0, 0, 1);
        chk("miss_stall_count", {16'd0, perf_stall_cycles}, 32'd6);
        step(0, 1, 0, 0, 0, 0);
        chk("miss_out_pc", out_pc, 32'h8000_0010);
        chk("miss_out_instr", out_instr, instr_of(32'h8000_0010));

        // Decode back-pressure.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, 0);
            chk("bp_out_pc", out_pc, 32'h8000_0010);
            chk("bp_pc", icache_address, 32'h8000_0014);
        end
        step(0, 1, 0, 0, 0, 1);
        chk("bp_release_pc", out_pc, 32'h8000_0014);

        // Redirect in RUN drops the concurrent hit.
        step(0, 1, 0, 1, 32'h8000_0103, 1);
        chk("rd_flush", {31'd0, out_valid}, 32'd0);
        step(0, 1, 0, 0, 0, 1);
        chk("rd_out_pc", out_pc, 32'h8000_0100);

        // Redirect arriving during a miss is deferred until the fill ends.
        step(0, 0, 0, 1, 32'h8000_0040, 1);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 1, 32'h8000_0200, 1);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 0, 0, 1);
            chk("pend_addr_hold", icache_address, 32'h8000_0040);
        end
        step(0, 1, 0, 0, 0, 1);
        chk("pend_applied", icache_address, 32'h8000_0200);
        chk("pend_no_output", {31'd0, out_valid}, 32'd0);
        step(0, 1, 0, 0, 0, 1);
        chk("pend_out_pc", out_pc, 32'h8000_0200);

        // Address wrap.
        step(0, 0, 0, 1, 32'hFFFF_FFFE, 1);
        step(0, 1, 0, 0, 0, 1);
        chk("wrap_addr", icache_address, 32'h0);
        chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);

        // Reset in the middle of a miss with a pending redirect.
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 1, 32'h1234_5678, 1);
        step(1, 0, 1, 0, 0, 1);
        chk("rst_mid_miss_en", {31'd0, icache_enable}, 32'd0);
        step(0, 1, 0, 0, 0, 1);
        chk("rst_mid_miss_pc", icache_address, 32'h8000_0000);

        // Randomized traffic against the model.
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            logic r, h, s, v, y;
            r = ($urandom_range(0, 199) == 0);
            if (burst > 0) begin
                s = 1; burst--;
            end else if ($urandom_range(0, 9) == 0) begin
                s = 1; burst = $urandom_range(0, 7);
            end else begin
                s = 0;
            end
            h = ($urandom_range(0, 4) != 0);
            v = ($urandom_range(0, 12) == 0);
            y = ($urandom_range(0, 9) < 7);
            tgt = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(r, h, s, v, tgt, y);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
